// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use bubble, branch redirect and memory freeze
// sequencing for the 5-stage pipeline, with saturating perf counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_rs, id_rt        source fields of the instruction in IF/ID
//   idex_memread/rt     load in ID/EX and its destination register
//   exmem_branch/zero   branch resolution from EX/MEM
//   exmem_memread/write data memory access in EX/MEM
//   dmem_ready          data memory completes the access this cycle
//   pc_wr, pc_src       PC write enable, 1 = load branch target
//   *_wr, *_flush       stage-register write enables / sync clears
//   mem_err             sticky memory timeout flag
//   stall_cnt/flush_cnt saturating stall and redirect counters
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt,
   input  logic             exmem_branch,
   input  logic             exmem_zero,
   input  logic             exmem_memread,
   input  logic             exmem_memwrite,
   input  logic             dmem_ready,
   output logic             pc_wr,
   output logic             pc_src,
   output logic             if_id_wr,
   output logic             id_ex_wr,
   output logic             ex_mem_wr,
   output logic             mem_wb_wr,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

   typedef enum logic {S_RUN, S_WAIT} state_t;

   state_t        state;
   state_t        state_nx;
   logic [WW-1:0] wait_cnt;

   logic mem_req;
   logic freeze;
   logic timeout;
   logic taken;
   logic loaduse;
   logic stall_inc;
   logic flush_inc;

   assign mem_req = exmem_memread | exmem_memwrite;
   assign freeze  = mem_req & ~dmem_ready & (wait_cnt < TMO);
   assign timeout = mem_req & ~dmem_ready & (wait_cnt == TMO);
   assign taken   = exmem_branch & exmem_zero;
   assign loaduse = idex_memread & (idex_rt != 5'd0) &
                    ((idex_rt == id_rs) | (idex_rt == id_rt));

   // A taken branch squashes the dependent instruction, so no bubble then.
   assign stall_inc = freeze | (~taken & loaduse);
   assign flush_inc = ~freeze & taken;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= freeze ? wait_cnt + 1'b1 : '0;
      end
   end

   // Next state: stay frozen only while the access is pending and in budget
   always_comb begin
      state_nx = S_RUN;
      if (freeze)
         state_nx = S_WAIT;
   end

   // Outputs
   always_comb begin
      pc_wr        = 1'b1;
      pc_src       = 1'b0;
      if_id_wr     = 1'b1;
      id_ex_wr     = 1'b1;
      ex_mem_wr    = 1'b1;
      mem_wb_wr    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      if (rst) begin
         pc_wr        = 1'b0;
         if_id_wr     = 1'b0;
         id_ex_wr     = 1'b0;
         ex_mem_wr    = 1'b0;
         mem_wb_wr    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (freeze) begin
         pc_wr     = 1'b0;
         if_id_wr  = 1'b0;
         id_ex_wr  = 1'b0;
         ex_mem_wr = 1'b0;
         mem_wb_wr = 1'b0;
      end else if (taken) begin
         pc_src       = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (loaduse) begin
         pc_wr       = 1'b0;
         if_id_wr    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   // Sticky error flag and saturating counters
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_err   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (timeout)
            mem_err <= 1'b1;
         if (stall_inc && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_inc && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for pipe_hazard_ctrl covering
// load-use, branch redirect, memory freeze, timeout, reset and saturation.
module tb_pipe_hazard_ctrl;

   localparam int TMO = 4;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    id_rs = '0, id_rt = '0, idex_rt = '0;
   logic          idex_memread = 0, exmem_branch = 0, exmem_zero = 0;
   logic          exmem_memread = 0, exmem_memwrite = 0, dmem_ready = 1;
   logic          pc_wr, pc_src, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
   logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .idex_memread(idex_memread), .idex_rt(idex_rt),
      .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
      .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
      .dmem_ready(dmem_ready), .pc_wr(pc_wr), .pc_src(pc_src),
      .if_id_wr(if_id_wr), .id_ex_wr(id_ex_wr), .ex_mem_wr(ex_mem_wr),
      .mem_wb_wr(mem_wb_wr), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
      .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // {pc_wr, pc_src, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
   //  if_id_flush, id_ex_flush, ex_mem_flush}
   localparam logic [8:0] NORM = 9'b1_0_1111_000;
   localparam logic [8:0] LU   = 9'b0_0_0111_010;
   localparam logic [8:0] TK   = 9'b1_1_1111_111;
   localparam logic [8:0] FRZ  = 9'b0_0_0000_000;
   localparam logic [8:0] RSTV = 9'b0_0_0000_111;
   localparam logic [8:0] ALL  = 9'h1FF;
   // id_ex_wr is left free during a load-use bubble (flush dominates)
   localparam logic [8:0] LUM  = 9'b1_1_1011_111;

   typedef struct {
      string      name;
      logic [4:0] rs, rt, ldrt;
      logic       ld, br, z, mrd, mwr, rdy;
      logic [8:0] exp, mask;
      logic       si, fi, te;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;
   int exp_stall = 0;
   int exp_flush = 0;
   logic exp_err = 1'b0;
   localparam int CMAX = (1 << CW) - 1;

   function automatic vec_t mk(string name, logic [4:0] rs, logic [4:0] rt,
                               logic ld, logic [4:0] ldrt, logic br,
                               logic z, logic mrd, logic mwr, logic rdy,
                               logic [8:0] exp, logic si, logic fi,
                               logic te);
      vec_t v;
      v.name = name; v.rs = rs; v.rt = rt; v.ld = ld; v.ldrt = ldrt;
      v.br = br; v.z = z; v.mrd = mrd; v.mwr = mwr; v.rdy = rdy;
      v.exp = exp; v.mask = (exp == LU) ? LUM : ALL;
      v.si = si; v.fi = fi; v.te = te;
      return v;
   endfunction

   task automatic chk(string name, int act, int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then advance model.
   task automatic step(vec_t v, logic r);
      logic [8:0] o;
      @(posedge clk);
      #1;
      rst = r;
      id_rs = v.rs; id_rt = v.rt; idex_memread = v.ld; idex_rt = v.ldrt;
      exmem_branch = v.br; exmem_zero = v.z;
      exmem_memread = v.mrd; exmem_memwrite = v.mwr; dmem_ready = v.rdy;
      @(negedge clk);
      o = {pc_wr, pc_src, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
           if_id_flush, id_ex_flush, ex_mem_flush};
      chk({v.name, ".outs"}, int'(o & v.mask), int'(v.exp & v.mask));
      chk({v.name, ".stall_cnt"}, int'(stall_cnt), exp_stall);
      chk({v.name, ".flush_cnt"}, int'(flush_cnt), exp_flush);
      chk({v.name, ".mem_err"}, int'(mem_err), int'(exp_err));
      if (r) begin
         exp_stall = 0; exp_flush = 0; exp_err = 1'b0;
      end else begin
         if (v.si && exp_stall < CMAX) exp_stall++;
         if (v.fi && exp_flush < CMAX) exp_flush++;
         if (v.te) exp_err = 1'b1;
      end
   endtask

   vec_t tbl[$];
   vec_t idle, frz, rstv, lu;

   initial begin
      idle = mk("idle", 1, 2, 0, 0, 0, 0, 0, 0, 1, NORM, 0, 0, 0);
      frz  = mk("freeze", 1, 2, 0, 0, 0, 0, 1, 0, 0, FRZ, 1, 0, 0);
      rstv = mk("reset", 5, 5, 1, 5, 1, 1, 1, 0, 0, RSTV, 0, 0, 0);
      lu   = mk("lu_sat", 5, 7, 1, 5, 0, 0, 0, 0, 1, LU, 1, 0, 0);

      tbl.push_back(mk("normal",     1, 2, 0, 0, 0, 0, 0, 0, 1, NORM, 0, 0, 0));
      tbl.push_back(mk("lu_rs",      5, 7, 1, 5, 0, 0, 0, 0, 1, LU,   1, 0, 0));
      tbl.push_back(mk("lu_next",    5, 7, 0, 0, 0, 0, 0, 0, 1, NORM, 0, 0, 0));
      tbl.push_back(mk("lu_rt",      3, 9, 1, 9, 0, 0, 0, 0, 1, LU,   1, 0, 0));
      tbl.push_back(mk("lu_r0",      0, 0, 1, 0, 0, 0, 0, 0, 1, NORM, 0, 0, 0));
      tbl.push_back(mk("ld_nomatch", 4, 6, 1, 5, 0, 0, 0, 0, 1, NORM, 0, 0, 0));
      tbl.push_back(mk("taken",      1, 2, 0, 0, 1, 1, 0, 0, 1, TK,   0, 1, 0));
      tbl.push_back(mk("taken_lu",   5, 2, 1, 5, 1, 1, 0, 0, 1, TK,   0, 1, 0));
      tbl.push_back(mk("br_not",     5, 2, 0, 0, 1, 0, 0, 0, 1, NORM, 0, 0, 0));
      tbl.push_back(mk("zero_only",  0, 0, 0, 0, 0, 1, 0, 0, 1, NORM, 0, 0, 0));
      tbl.push_back(mk("st_ready",   1, 2, 0, 0, 0, 0, 0, 1, 1, NORM, 0, 0, 0));
      tbl.push_back(mk("ld_rdy_lu",  5, 2, 1, 5, 0, 0, 1, 0, 1, LU,   1, 0, 0));
      tbl.push_back(mk("idle",       1, 2, 0, 0, 0, 0, 0, 0, 1, NORM, 0, 0, 0));

      // Outputs while reset is held
      step(rstv, 1'b1);
      step(rstv, 1'b1);

      foreach (tbl[i]) step(tbl[i], 1'b0);

      // Memory wait: three frozen cycles, then ready
      for (int i = 0; i < 3; i++) step(frz, 1'b0);
      step(mk("mw_ready", 1, 2, 0, 0, 0, 0, 1, 0, 1, NORM, 0, 0, 0), 1'b0);
      step(idle, 1'b0);

      // Freeze outranks a coincident taken branch; taken acts after release
      step(mk("frz_tk", 1, 2, 0, 0, 1, 1, 1, 0, 0, FRZ, 1, 0, 0), 1'b0);
      step(mk("tk_rel", 1, 2, 0, 0, 1, 1, 1, 0, 1, TK,  0, 1, 0), 1'b0);
      step(idle, 1'b0);

      // Timeout: TMO frozen cycles, next cycle released with mem_err set
      for (int i = 0; i < TMO; i++) step(frz, 1'b0);
      step(mk("timeout", 1, 2, 0, 0, 0, 0, 1, 0, 0, NORM, 0, 0, 1), 1'b0);
      step(idle, 1'b0);
      step(mk("clean_st", 1, 2, 0, 0, 0, 0, 0, 1, 1, NORM, 0, 0, 0), 1'b0);
      step(idle, 1'b0);

      // Reset on the second freeze cycle abandons the wait
      step(frz, 1'b0);
      step(rstv, 1'b1);
      step(idle, 1'b0);
      step(frz, 1'b0);
      step(mk("post_rdy", 1, 2, 0, 0, 0, 0, 1, 0, 1, NORM, 0, 0, 0), 1'b0);

      // Stall counter saturation
      for (int i = 0; i < CMAX + 4; i++) step(lu, 1'b0);
      step(idle, 1'b0);
      chk("stall_sat", int'(stall_cnt), CMAX);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing unit for the 5-stage pipeline. It drives the write-enable (IRWr-style) and synchronous flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, plus the PC write and PC source select. It handles three cases: a load-use bubble, branch-taken redirect resolved from EX/MEM branch/zero, and a full-pipeline freeze while data memory is not ready (with a timeout). It also keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive freeze cycles per memory access before forced release.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
id_rs  in  5  rs field of the instruction in IF/ID.
id_rt  in  5  rt field of the instruction in IF/ID.
idex_memread  in  1  ID/EX holds a load.
idex_rt  in  5  destination register of the load in ID/EX.
exmem_branch  in  1  EX/MEM branch flag.
exmem_zero  in  1  EX/MEM zero flag.
exmem_memread  in  1  EX/MEM load.
exmem_memwrite  in  1  EX/MEM store.
dmem_ready  in  1  data memory completes the access this cycle.
pc_wr  out  1  PC write enable.
pc_src  out  1  1 = load branch target into PC.
if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr  out  1 each  stage-register write enables.
if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  stage-register synchronous clear.
mem_err  out  1  sticky flag: a memory timeout occurred.
stall_cnt  out  CNT_W  count of stalled cycles, saturating.
flush_cnt  out  CNT_W  count of branch redirects, saturating.

Behaviour:
- Outputs are combinational (Mealy) from state and inputs. State, wait_cnt, mem_err and counters are registered.
- While rst=1: all *_wr=0, pc_src=0, and all *_flush=1. At the reset edge: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0. Reset mid-freeze abandons the wait immediately.
- States: RUN and WAIT. wait_cnt has width clog2(MEM_TIMEOUT+1) and is 0 whenever the state is RUN.
- Condition signals:
  - mem_req = exmem_memread | exmem_memwrite.
  - freeze = mem_req & ~dmem_ready & (wait_cnt < MEM_TIMEOUT).
  - timeout = mem_req & ~dmem_ready & (wait_cnt == MEM_TIMEOUT).
  - taken = exmem_branch & exmem_zero.
  - loaduse = idex_memread & (idex_rt != 0) & (idex_rt == id_rs | idex_rt == id_rt).
- Priority is freeze > taken > loaduse > normal.
  - Normal: all *_wr=1, all flush=0, pc_src=0.
  - Freeze: all *_wr=0 (pc included), flush=0, pc_src=0. stall_cnt increments. wait_cnt increments. next state=WAIT.
  - Taken: pc_wr=1, pc_src=1, all *_wr=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1. flush_cnt increments. loaduse is ignored that cycle.
  - Loaduse: pc_wr=0, if_id_wr=0, id_ex_flush=1, ex_mem_wr=1, mem_wb_wr=1. This gives exactly 1 bubble cycle. stall_cnt increments.
- WAIT exit:
  - WAIT to RUN on dmem_ready=1. That cycle is normal and wait_cnt is cleared.
  - WAIT to RUN on timeout. That cycle is treated as ready (normal outputs), mem_err is set to 1 at the edge, and wait_cnt is cleared.
  - Result: at most MEM_TIMEOUT frozen cycles per access.
- mem_err is cleared only by rst.
- Counters hold at 2^CNT_W-1; they never wrap.
- mem_req and taken are mutually exclusive by ISA. If both are asserted, freeze still wins and taken is re-evaluated after release.

Test Plan:
- Load-use: ID/EX holds lw with rt=5, IF/ID rs=5, clean otherwise. Required: 1 cycle of pc_wr=0, if_id_wr=0, id_ex_flush=1. Next cycle normal. stall_cnt=1.
- Load-use to $0: idex_rt=0, id_rs=0, idex_memread=1. Required: no stall, all wr=1.
- Branch taken together with load-use in the same cycle: exmem_branch=1, exmem_zero=1. Required: pc_src=1, the three flushes=1, pc_wr=1, no bubble. flush_cnt=1, stall_cnt unchanged.
- Memory wait: exmem_memread=1 with dmem_ready low for 3 cycles, then high. Required: exactly 3 cycles with all wr=0, then normal. stall_cnt=3, mem_err=0.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0. Required: 4 frozen cycles, 5th cycle normal. mem_err=1 afterwards and stays set across later clean accesses.
- Reset mid-WAIT: assert rst on the 2nd freeze cycle. Required: flushes=1 and wr=0 during reset. After reset: state RUN, counters 0, mem_err 0. The first cycle with mem_req=0 is normal.
